// File: rtl/pipe_regfile_if.sv
// -----------------------------------------------------------------------------
// pipe_regfile_if
// Bundle of read, issue and write-back signals between the ID stage (master)
// and the pipelined register file (slave).
// -----------------------------------------------------------------------------
interface pipe_regfile_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
);

   // Read ports
   logic [ADDR_W-1:0] rr1;
   logic [ADDR_W-1:0] rr2;
   logic [WIDTH-1:0]  rd1;
   logic [WIDTH-1:0]  rd2;
   logic              busy1;
   logic              busy2;
   logic              stall;

   // Issue port: a producer of issue_wr leaves ID
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_wr;
   logic              issue_ready;

   // Write-back port
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_wr;
   logic [WIDTH-1:0]  wb_wd;
   logic              wb_err;

   // ID stage side
   modport master (
      output rr1, rr2, issue_valid, issue_wr, wb_valid, wb_wr, wb_wd,
      input  rd1, rd2, busy1, busy2, stall, issue_ready, wb_err
   );

   // Register file side
   modport slave (
      input  rr1, rr2, issue_valid, issue_wr, wb_valid, wb_wr, wb_wd,
      output rd1, rd2, busy1, busy2, stall, issue_ready, wb_err
   );

endinterface

// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
// Parametrised register file for the ID stage with a per-register count of
// outstanding producers, so ID can stall on read-after-write hazards.
// Register 0 is hard-wired to zero and never tracked.
//
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data to
// the read ports in the same cycle and release busy when the last pending
// producer retires in that cycle. Without it, readers see the stored value
// only and stall one extra cycle after write-back.
// -----------------------------------------------------------------------------
module pipe_regfile #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2,
   parameter int PEND_W = 2
) (
   input  logic           clock,
   input  logic           reset_n,
   pipe_regfile_if.slave  bus
);

   localparam int                NREGS   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] REG0    = '0;
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   // Architectural state
   logic [WIDTH-1:0]  r_regs [NREGS];
   logic [PEND_W-1:0] r_cnt  [NREGS];
   logic              r_wb_err;

   // Decoded control
   logic              w_wb_live;
   logic              w_issue_ready;
   logic [NREGS-1:0]  w_inc;
   logic [NREGS-1:0]  w_dec;

   // Read port views, index 0 = port 1, index 1 = port 2
   logic [ADDR_W-1:0] w_rr   [2];
   logic [WIDTH-1:0]  w_rd   [2];
   logic              w_busy [2];

   assign w_rr[0] = bus.rr1;
   assign w_rr[1] = bus.rr2;

   // A write-back that actually targets storage (register 0 is discarded)
   assign w_wb_live = bus.wb_valid && (bus.wb_wr != REG0);

   // Issue may proceed unless the destination counter would overflow
   assign w_issue_ready = (bus.issue_wr == REG0) || (r_cnt[bus.issue_wr] != CNT_MAX);

   // Per-register increment/decrement requests for the pending counters
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_inc = '0;
      w_dec = '0;
      for (int i = 1; i < NREGS; i++) begin
         w_inc[i] = bus.issue_valid && w_issue_ready && (bus.issue_wr == ADDR_W'(i));
         w_dec[i] = bus.wb_valid && (bus.wb_wr == ADDR_W'(i)) && (r_cnt[i] != '0);
      end
   end

   // Read data and busy for both ports, with optional write-back forwarding
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd[p]   = '0;
         w_busy[p] = 1'b0;
         if (w_rr[p] != REG0) begin
            w_rd[p]   = r_regs[w_rr[p]];
            w_busy[p] = (r_cnt[w_rr[p]] != '0);
`ifdef REGFILE_BYPASS_EN
            if (bus.wb_valid && (bus.wb_wr == w_rr[p])) begin
               w_rd[p] = bus.wb_wd;
               // The retiring producer is the last one: its data is the forwarded value
               if (r_cnt[w_rr[p]] == CNT_ONE) begin
                  w_busy[p] = 1'b0;
               end
            end
`endif
         end
      end
   end

   // Storage update: write-back lands in its register, register 0 stays zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the array is reset because all registers must read 0 after reset;
         // this forces flops rather than a RAM macro, which is fine at this size.
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_live) begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         r_regs[bus.wb_wr] <= bus.wb_wd;
      end
   end

   // Pending counters: issue adds a producer, write-back retires one; both cancel
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            case ({w_inc[i], w_dec[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + CNT_ONE;
               2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
      end
   end

   // Sticky error: write-back to a real register with no producer outstanding
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wb_err <= 1'b0;
      end else if (w_wb_live && (r_cnt[bus.wb_wr] == '0)) begin
         r_wb_err <= 1'b1;
      end
   end

   assign bus.rd1         = w_rd[0];
   assign bus.rd2         = w_rd[1];
   assign bus.busy1       = w_busy[0];
   assign bus.busy2       = w_busy[1];
   assign bus.stall       = w_busy[0] | w_busy[1];
   assign bus.issue_ready = w_issue_ready;
   assign bus.wb_err      = r_wb_err;

endmodule

// File: tb/tb_pipe_regfile.sv
// -----------------------------------------------------------------------------
// tb_pipe_regfile
// Self-checking bench for pipe_regfile (default parameters 16 x 4, PEND_W=2).
// Each test builds a table of cycles; driving a cycle pushes its expected
// outputs to a scoreboard queue, which is popped and compared once the
// combinational outputs have settled, away from the rising edge.
// Expectations for REGFILE_BYPASS_EN builds are selected with BYP.
// -----------------------------------------------------------------------------
module tb_pipe_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock;
   logic reset_n;

   pipe_regfile_if #(.WIDTH(16), .ADDR_W(2)) bus ();

   pipe_regfile #(.WIDTH(16), .ADDR_W(2), .PEND_W(2)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic        busy1;
      logic        busy2;
      logic        stall;
      logic        ready;
      logic        err;
   } obs_t;

   typedef struct {
      string name;
      obs_t  v;
   } exp_t;

   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  rr1;
      logic [1:0]  rr2;
      logic        iv;
      logic [1:0]  iw;
      logic        wv;
      logic [1:0]  ww;
      logic [15:0] wd;
      logic [15:0] e_rd1;
      logic [15:0] e_rd2;
      logic        e_b1;
      logic        e_b2;
      logic        e_rdy;
      logic        e_err;
   } step_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Build one cycle: reset level, inputs, then expected outputs
   function automatic step_t st(string name, int rst, int rr1, int rr2, int iv, int iw,
                                int wv, int ww, int wd, int e_rd1, int e_rd2,
                                int e_b1, int e_b2, int e_rdy, int e_err);
      step_t s;
      s.name  = name;
      s.rst   = 1'(rst);
      s.rr1   = 2'(rr1);
      s.rr2   = 2'(rr2);
      s.iv    = 1'(iv);
      s.iw    = 2'(iw);
      s.wv    = 1'(wv);
      s.ww    = 2'(ww);
      s.wd    = 16'(wd);
      s.e_rd1 = 16'(e_rd1);
      s.e_rd2 = 16'(e_rd2);
      s.e_b1  = 1'(e_b1);
      s.e_b2  = 1'(e_b2);
      s.e_rdy = 1'(e_rdy);
      s.e_err = 1'(e_err);
      return s;
   endfunction

   // Drive one cycle's inputs and push what the outputs must be
   task automatic apply(input step_t s);
      exp_t e;
      reset_n         = s.rst;
      bus.rr1         = s.rr1;
      bus.rr2         = s.rr2;
      bus.issue_valid = s.iv;
      bus.issue_wr    = s.iw;
      bus.wb_valid    = s.wv;
      bus.wb_wr       = s.ww;
      bus.wb_wd       = s.wd;
      e.name    = s.name;
      e.v.rd1   = s.e_rd1;
      e.v.rd2   = s.e_rd2;
      e.v.busy1 = s.e_b1;
      e.v.busy2 = s.e_b2;
      e.v.stall = s.e_b1 | s.e_b2;
      e.v.ready = s.e_rdy;
      e.v.err   = s.e_err;
      exp_q.push_back(e);
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.rd1   = bus.rd1;
      o.rd2   = bus.rd2;
      o.busy1 = bus.busy1;
      o.busy2 = bus.busy2;
      o.stall = bus.stall;
      o.ready = bus.issue_ready;
      o.err   = bus.wb_err;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("rd1=%h rd2=%h busy1=%b busy2=%b stall=%b ready=%b err=%b",
                       o.rd1, o.rd2, o.busy1, o.busy2, o.stall, o.ready, o.err);
   endfunction

   // Reset held with random inputs, then release and read every register
   task automatic test_reset();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      for (int k = 0; k < 4; k++) begin
         s.push_back(st("reset_hold", 0, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 1), $urandom_range(0, 3), 0,
                        $urandom_range(0, 3), $urandom_range(0, 65535),
                        0, 0, 0, 0, 1, 0));
      end
      for (int k = 0; k < 4; k++) begin
         s.push_back(st("reset_read", 1, k, 3 - k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   // Plain write-back then read; the first write hits a zero count and sets wb_err
   task automatic test_basic_rw();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      s.push_back(st("bw_wb1",  1, 1, 2, 0, 0, 1, 1, 16'h000F, BYP ? 15 : 0, 0, 0, 0, 1, 0));
      s.push_back(st("bw_wb2",  1, 1, 2, 0, 0, 1, 2, 16'h0007, 15, BYP ? 7 : 0, 0, 0, 1, 1));
      s.push_back(st("bw_read", 1, 1, 2, 0, 0, 0, 0, 0,        15, 7, 0, 0, 1, 1));
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   // Reset (clears wb_err), issue reg3, observe busy, then retire it
   task automatic test_scoreboard();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      s.push_back(st("sb_reset", 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
      s.push_back(st("sb_issue", 1, 3, 0, 1, 3, 0, 0, 0,  0, 0, 0, 0, 1, 0));
      s.push_back(st("sb_busy",  1, 3, 0, 0, 3, 0, 0, 0,  0, 0, 1, 0, 1, 0));
      s.push_back(st("sb_wb",    1, 3, 0, 0, 3, 1, 3, 22, BYP ? 22 : 0, 0, BYP ? 0 : 1, 0, 1, 0));
      s.push_back(st("sb_done",  1, 3, 0, 0, 3, 0, 0, 0,  22, 0, 0, 0, 1, 0));
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   // Saturate reg2 at three producers, drop a fourth issue, retire all three
   task automatic test_saturation();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      s.push_back(st("sat_issue1", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      s.push_back(st("sat_issue2", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      s.push_back(st("sat_issue3", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      s.push_back(st("sat_drop",   1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      s.push_back(st("sat_wb1",    1, 2, 0, 0, 2, 1, 2, 16'h0A21,
                     BYP ? 16'h0A21 : 0, 0, 1, 0, 0, 0));
      s.push_back(st("sat_wb2",    1, 2, 0, 0, 2, 1, 2, 16'h0B22,
                     BYP ? 16'h0B22 : 16'h0A21, 0, 1, 0, 1, 0));
      s.push_back(st("sat_wb3",    1, 2, 0, 0, 2, 1, 2, 16'h0C23,
                     BYP ? 16'h0C23 : 16'h0B22, 0, BYP ? 0 : 1, 0, 1, 0));
      s.push_back(st("sat_idle",   1, 2, 0, 0, 2, 0, 0, 0, 16'h0C23, 0, 0, 0, 1, 0));
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   // Issue and write-back to reg1 in the same cycle keeps its count at one
   task automatic test_simultaneous();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      s.push_back(st("sim_issue", 1, 1, 3, 1, 1, 0, 0, 0, 0, 22, 0, 0, 1, 0));
      s.push_back(st("sim_both",  1, 1, 3, 1, 1, 1, 1, 5, BYP ? 5 : 0, 22, BYP ? 0 : 1, 0, 1, 0));
      s.push_back(st("sim_hold",  1, 1, 3, 0, 1, 0, 0, 0, 5, 22, 1, 0, 1, 0));
      s.push_back(st("sim_wb",    1, 1, 3, 0, 1, 1, 1, 6, BYP ? 6 : 5, 22, BYP ? 0 : 1, 0, 1, 0));
      s.push_back(st("sim_idle",  1, 1, 3, 0, 0, 0, 0, 0, 6, 22, 0, 0, 1, 0));
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   // Register 0 ignores issue and write-back; async reset drops pending counts
   task automatic test_reg0_and_reset();
      step_t s[$];
      exp_t  ex;
      obs_t  obs;
      s.push_back(st("r0_both",   1, 0, 0, 1, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 1, 0));
      s.push_back(st("r0_read",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      s.push_back(st("r0_issue1", 1, 1, 2, 1, 1, 0, 0, 0, 6, 16'h0C23, 0, 0, 1, 0));
      s.push_back(st("r0_issue2", 1, 1, 2, 1, 2, 0, 0, 0, 6, 16'h0C23, 1, 0, 1, 0));
      s.push_back(st("r0_rst",    0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      s.push_back(st("r0_after",  1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      foreach (s[k]) begin
         apply(s[k]);
         #1;
         ex  = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== ex.v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %s / want %s", ex.name, k, fmt(obs), fmt(ex.v));
         end
         @(negedge clock);
      end
   endtask

   initial begin
      reset_n         = 1'b1;
      bus.rr1         = '0;
      bus.rr2         = '0;
      bus.issue_valid = 1'b0;
      bus.issue_wr    = '0;
      bus.wb_valid    = 1'b0;
      bus.wb_wr       = '0;
      bus.wb_wd       = '0;
      #2 reset_n = 1'b0;
      @(negedge clock);

      test_reset();
      test_basic_rw();
      test_scoreboard();
      test_saturation();
      test_simultaneous();
      test_reg0_and_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
